// File: rtl/input_buffer_q.sv
// Keypad command-stream to binary-operation converter with editing and an output queue.
// Command codes are shared with the rest of the calculator through input_buffer_q_pkg.
package input_buffer_q_pkg;
  localparam int unsigned IC_N = 4;

  localparam logic [IC_N-1:0] IC_NONE = IC_N'(0);
  localparam logic [IC_N-1:0] IC_D0   = IC_N'(1);
  localparam logic [IC_N-1:0] IC_D9   = IC_N'(10);
  localparam logic [IC_N-1:0] IC_OPAD = IC_N'(11);
  localparam logic [IC_N-1:0] IC_OPSB = IC_N'(12);
  localparam logic [IC_N-1:0] IC_CTOK = IC_N'(13);
  localparam logic [IC_N-1:0] IC_BKSP = IC_N'(14);
  localparam logic [IC_N-1:0] IC_CLR  = IC_N'(15);
endpackage

module input_buffer_q
  import input_buffer_q_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned QDEPTH = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [IC_N-1:0]         cmd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_src,
  output logic [WIDTH-1:0]        out_dst,
  output logic [IC_N-1:0]         out_op,
  output logic                    out_chain,
  output logic                    out_finish,
  output logic [WIDTH-1:0]        cur_value,
  output logic                    overflow,
  output logic                    drop,
  output logic [$clog2(QDEPTH):0] q_count
);
  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = WIDTH + 4;

  typedef enum logic [1:0] {S_IDLE, S_SRC, S_OPR, S_DST} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] dst;
    logic [IC_N-1:0]  op;
    logic             chain;
    logic             finish;
  } entry_t;

  state_t           state;
  logic [WIDTH-1:0] src_q;
  logic [WIDTH-1:0] dst_q;
  logic [IC_N-1:0]  op_q;
  logic             chain_q;

  entry_t           mem [QDEPTH];
  entry_t           head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic             is_digit;
  logic             is_op;
  logic             is_ctok;
  logic [3:0]       digit;
  logic [WIDTH-1:0] edit_val;
  logic [WIDTH-1:0] edit_div;
  logic [PW-1:0]    acc;
  logic             acc_ovf;
  logic             do_pop;
  logic             full;
  logic             push_ok;
  entry_t           push_entry;

  // Command decode, operand arithmetic and the entry a CTOK would push
  always_comb begin
    is_digit = (cmd >= IC_D0) && (cmd <= IC_D9);
    is_op    = (cmd == IC_OPAD) || (cmd == IC_OPSB);
    is_ctok  = (cmd == IC_CTOK);
    digit    = 4'(cmd - IC_D0);
    edit_val = (state == S_DST) ? dst_q : src_q;
    edit_div = edit_val / WIDTH'(10);
    acc      = PW'(edit_val) * PW'(10) + PW'(digit);
    acc_ovf  = |acc[PW-1:WIDTH];
    do_pop   = out_valid && out_ready;
    full     = (count == CW'(QDEPTH));
    push_ok  = is_ctok && (!full || do_pop);

    push_entry    = '0;
    push_entry.op = IC_NONE;
    case (state)
      S_IDLE: push_entry.finish = 1'b1;
      S_SRC: begin
        push_entry.src = src_q;
        push_entry.op  = IC_OPAD;
      end
      default: begin
        push_entry.src   = src_q;
        push_entry.dst   = dst_q;
        push_entry.op    = op_q;
        push_entry.chain = chain_q;
      end
    endcase
  end

  // Edit state machine; a dropped CTOK leaves everything in place for a retry
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      op_q     <= IC_NONE;
      chain_q  <= 1'b0;
      overflow <= 1'b0;
    end else if (cmd == IC_CLR || push_ok) begin
      state    <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      op_q     <= IC_NONE;
      chain_q  <= 1'b0;
      overflow <= 1'b0;
    end else if (is_digit) begin
      case (state)
        S_IDLE: begin
          src_q   <= WIDTH'(digit);
          chain_q <= 1'b0;
          state   <= S_SRC;
        end
        S_OPR: begin
          dst_q <= WIDTH'(digit);
          state <= S_DST;
        end
        default: begin
          if (acc_ovf)
            overflow <= 1'b1;
          else if (state == S_SRC)
            src_q <= acc[WIDTH-1:0];
          else
            dst_q <= acc[WIDTH-1:0];
        end
      endcase
    end else if (is_op) begin
      case (state)
        S_IDLE: begin
          chain_q <= 1'b1;
          src_q   <= '0;
          op_q    <= cmd;
          state   <= S_OPR;
        end
        S_SRC, S_OPR: begin
          op_q  <= cmd;
          state <= S_OPR;
        end
        default: ;
      endcase
    end else if (cmd == IC_BKSP) begin
      case (state)
        S_SRC: begin
          src_q <= edit_div;
          if (edit_div == '0) state <= S_IDLE;
        end
        S_DST: begin
          dst_q <= edit_div;
          if (edit_div == '0) state <= S_OPR;
        end
        S_OPR: begin
          op_q    <= IC_NONE;
          chain_q <= 1'b0;
          state   <= chain_q ? S_IDLE : S_SRC;
        end
        default: ;
      endcase
    end
  end

  // Queue pointers, occupancy and the drop pulse
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else begin
      drop <= is_ctok && !push_ok;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(do_pop);
    end
  end

  always_ff @(posedge Clock) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  assign head       = mem[rd_ptr];
  assign out_valid  = (count != '0);
  assign out_src    = out_valid ? head.src    : '0;
  assign out_dst    = out_valid ? head.dst    : '0;
  assign out_op     = out_valid ? head.op     : IC_NONE;
  assign out_chain  = out_valid ? head.chain  : 1'b0;
  assign out_finish = out_valid ? head.finish : 1'b0;
  assign cur_value  = (state == S_OPR || state == S_DST) ? dst_q : src_q;
  assign q_count    = count;

endmodule

// File: doc/input_buffer_q.md
Name: input_buffer_q

Overview:
Parametrised successor to the calculator's keypad input buffer. Converts the per-cycle command stream (IC_* codes, IC_N bits wide) into complete binary operations {SRC, DST, op, chain, finish}. Adds configurable operand width, decimal overflow detection, backspace/clear editing, and a QDEPTH-entry output queue with a valid/ready handshake to the ALU sequencer.

Parameters:
WIDTH, 16, operand width in bits (unsigned decimal entry)
QDEPTH, 4, output queue depth in entries (power of 2, >=2)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
cmd  input  IC_N  command code; IC_NONE = no event; every other code is one event per cycle
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head when out_valid & out_ready at rising edge
out_src  output  WIDTH  head: first operand
out_dst  output  WIDTH  head: second operand
out_op  output  IC_N  head: operator code (IC_OPAD/IC_OPSB; IC_NONE for finish entries)
out_chain  output  1  head: SRC is the ALU's previous result; out_src = 0
out_finish  output  1  head: end-of-expression marker
cur_value  output  WIDTH  operand currently being edited (for display)
overflow  output  1  sticky; set on a rejected digit, cleared by IC_CLR/CTOK/reset
drop  output  1  one-cycle pulse: a CTOK was discarded because the queue was full
q_count  output  $clog2(QDEPTH)+1  occupied entries

Behaviour:
- Reset (async, Reset=0): state IDLE, src/dst/op/chain cleared, queue empty; out_valid=0, out_* = 0, out_op = IC_NONE, cur_value=0, overflow=0, drop=0, q_count=0.
- Commands are sampled at each rising edge. New codes IC_BKSP and IC_CLR are defined in the shared input-interface header.
- States:
  - IDLE: nothing entered.
  - SRC: entering src.
  - OPR: operator latched, dst empty.
  - DST: entering dst.
- Digit d: IDLE->SRC with src=d. In SRC, src=src*10+d. OPR->DST with dst=d. In DST, dst=dst*10+d.
- Digit arithmetic: the product is computed WIDTH+4 bits wide. If the result exceeds 2^WIDTH-1, the digit is rejected, the operand is unchanged, and overflow=1.
- Operator in IDLE: chain=1, src=0, ->OPR. In SRC: ->OPR. In OPR: replaces op. In DST: ignored.
- IC_BKSP:
  - SRC: src=src/10; if src becomes 0, ->IDLE.
  - DST: dst=dst/10; if dst becomes 0, ->OPR.
  - OPR: ->SRC, or ->IDLE when chain=1.
  - IDLE: no effect.
- IC_CLR: ->IDLE, all fields cleared, overflow=0. The queue is untouched.
- IC_CTOK:
  - DST or OPR (dst=0): push {src,dst,op,chain,finish=0}, ->IDLE.
  - IDLE: push finish entry {0,0,IC_NONE,0,1}.
  - SRC: push {src,0,IC_OPAD,0,0}, i.e. src+0.
  - Any successful push clears overflow.
- Queue full, no same-cycle pop: CTOK is discarded, drop pulses for 1 cycle, edit state is kept unchanged for retry.
- Queue full with same-cycle pop (out_valid & out_ready): push succeeds.
- Latency: CTOK sampled at edge N; the entry is visible (out_valid=1, out_* stable) after edge N when the queue was empty.
- out_* hold stable while out_valid=1 and out_ready=0.
- Pop and push in the same cycle: q_count unchanged, FIFO order preserved. Pointers wrap modulo QDEPTH.
- cur_value = dst in OPR/DST, src otherwise (OPR shows 0).
- Reset mid-entry or with a non-empty queue discards everything immediately (asynchronous).

Test Plan:
- out_ready=1; cmd 5,6,OPAD,3,7,CTOK -> one entry src=56 dst=37 op=IC_OPAD chain=0 finish=0, out_valid for exactly 1 cycle after the CTOK edge.
- Continue with OPSB,4,9,CTOK,CTOK -> entry chain=1 src=0 dst=49 op=IC_OPSB, then entry finish=1 op=IC_NONE.
- WIDTH=16; digits 6,5,5,3,6 -> cur_value=6553, overflow=1. Then CTOK -> entry src=6553 op=IC_OPAD, overflow=0.
- Edit path: 1,2,3,BKSP,OPAD,OPSB,9,BKSP,BKSP -> state SRC with cur_value=12. Then OPAD,4,CTOK -> src=12 dst=4 op=IC_OPAD.
- QDEPTH=2, out_ready=0; three expressions 1+1, 2+2, 3+3 -> q_count=2, drop pulses on the third CTOK, cur_value still 3. Raise out_ready -> entries drain in order 1+1, 2+2; then CTOK pushes 3+3.
- Reset low mid-DST with 2 entries queued -> out_valid=0, q_count=0, cur_value=0 immediately. After release, 8,CTOK -> src=8 op=IC_OPAD.
